sort_serializer: RTL and testbench

Back-end companion to the five-input sorter. Accepts one sorted frame of N unsigned words per handshake and streams the words out one per cycle, in ascending order (word 0 first), over a valid/ready interface. A two-slot frame buffer decouples the sorter's parallel output from a slower serial consumer.

---
 rtl/sort_pkg.sv | 14 +
 rtl/sort_order_check.sv | 21 ++
 rtl/sort_serializer.sv | 116 +++++++++++
 tb/tb_sort_serializer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sort back-end: default sizes, occupancy states
// and the packed frame type (word 0 in the low bits).
package sort_pkg;
  localparam int SORT_DW = 16;
  localparam int SORT_N  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef logic [SORT_N-1:0][SORT_DW-1:0] frame_t;
endpackage

// File: rtl/sort_order_check.sv
// Combinational check that an N-word frame is nondecreasing (unsigned).
// Equal neighbours count as ordered.
module sort_order_check
  import sort_pkg::*;
#(
  parameter int DW = SORT_DW,
  parameter int N  = SORT_N
) (
  input  logic [N*DW-1:0] words_i,
  output logic            ordered_o
);

  // Any descending adjacent pair clears the ordered flag
  always_comb begin
    ordered_o = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (words_i[i*DW +: DW] > words_i[(i+1)*DW +: DW]) ordered_o = 1'b0;
    end
  end

endmodule

// File: rtl/sort_serializer.sv
// Two-slot frame buffer that streams each sorted frame out word 0 first.
// Optional order checking is built when SORT_SER_CHECK_EN is defined;
// otherwise sort_err is tied low.
module sort_serializer
  import sort_pkg::*;
#(
  parameter int DW = SORT_DW,
  parameter int N  = SORT_N,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frm_valid,
  output logic          frm_ready,
  input  logic [N*DW-1:0] frm_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_first,
  output logic          out_last,
  output logic          sort_err
);

  occ_e            state_q, state_d;
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N*DW-1:0] slot_q [2];

  logic frm_acc, wd_acc, is_last, release_w;

  // Ready is forced high while in reset; no capture happens then anyway.
  assign frm_ready = rst || (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign frm_acc   = frm_valid && frm_ready && !rst;
  assign wd_acc    = out_valid && out_ready;
  assign is_last   = (idx_q == IW'(N - 1));
  assign release_w = wd_acc && is_last;

  assign out_data  = slot_q[rp_q][int'(idx_q)*DW +: DW];
  assign out_idx   = idx_q;
  assign out_first = out_valid && (idx_q == '0);
  assign out_last  = out_valid && is_last;

  // Next-state: pointers, word index and occupancy
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q ^ frm_acc;
    rp_d    = rp_q;
    idx_d   = idx_q;
    if (wd_acc) begin
      if (is_last) begin
        idx_d = '0;
        rp_d  = ~rp_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    unique case (state_q)
      EMPTY: if (frm_acc) state_d = ONE;
      ONE: begin
        if (frm_acc && !release_w)      state_d = FULL;
        else if (release_w && !frm_acc) state_d = EMPTY;
      end
      FULL:    if (release_w) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      idx_q   <= idx_d;
    end
  end

  // Frame slots: data-only, written on accept, no reset needed
  always_ff @(posedge clk) begin
    if (frm_acc) slot_q[wp_q] <= frm_data;
  end

`ifdef SORT_SER_CHECK_EN
  logic ordered;
  logic err_q, err_d;

  sort_order_check #(.DW(DW), .N(N)) u_chk (
    .words_i   (frm_data),
    .ordered_o (ordered)
  );

  // Sticky flag: set by any accepted out-of-order frame
  always_comb begin
    err_d = err_q | (frm_acc & ~ordered);
  end

  // Error register
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign sort_err = err_q;
`else
  assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_serializer.sv
// Bench for sort_serializer: directed test-plan steps plus random frames,
// checked against a frame-queue reference model.
module tb_sort_serializer;
  import sort_pkg::*;

  localparam int DW = SORT_DW;
  localparam int N  = SORT_N;

  logic          clk = 1'b0;
  logic          rst;
  logic          frm_valid;
  logic          frm_ready;
  frame_t        frm_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_idx;
  logic          out_first;
  logic          out_last;
  logic          sort_err;

  sort_serializer dut (
    .clk(clk), .rst(rst),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_first(out_first), .out_last(out_last),
    .sort_err(sort_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: frames held, position inside the head frame, error flag
  frame_t mq[$];
  int     mpos;
  bit     merr;
  frame_t pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk(input int a0, a1, a2, a3, a4);
    frame_t f;
    f[0] = a0[DW-1:0]; f[1] = a1[DW-1:0]; f[2] = a2[DW-1:0];
    f[3] = a3[DW-1:0]; f[4] = a4[DW-1:0];
    return f;
  endfunction

  function automatic bit unsorted(input frame_t f);
    for (int i = 0; i < N - 1; i++) if (f[i] > f[i+1]) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle, entered and left at a negedge: check, drive, clock, update model
  task automatic step(input bit ordy, input bit fv_en);
    bit ev, er, af, aw;
    ev = (mq.size() > 0);
    er = (mq.size() < 2);
    chk("frm_ready", frm_ready, er);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_data",  out_data,  mq[0][mpos]);
      chk("out_idx",   out_idx,   mpos);
      chk("out_first", out_first, mpos == 0);
      chk("out_last",  out_last,  mpos == N - 1);
    end else begin
      chk("out_first_idle", out_first, 1'b0);
      chk("out_last_idle",  out_last,  1'b0);
    end
`ifdef SORT_SER_CHECK_EN
    chk("sort_err", sort_err, merr);
`else
    chk("sort_err", sort_err, 1'b0);
`endif
    frm_valid = fv_en && (pend.size() > 0);
    frm_data  = frm_valid ? pend[0] : frame_t'($urandom());
    out_ready = ordy;
    @(posedge clk);
    af = frm_valid && er;
    aw = ev && ordy;
    if (aw) begin
      mpos++;
      if (mpos == N) begin
        void'(mq.pop_front());
        mpos = 0;
      end
    end
    if (af) begin
      if (unsorted(pend[0])) merr = 1'b1;
      mq.push_back(pend.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    frm_valid = 1'b1;
    frm_data  = mk(99, 98, 97, 96, 95);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_frm_ready", frm_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_first",     out_first, 1'b0);
    chk("rst_last",      out_last,  1'b0);
    chk("rst_sort_err",  sort_err,  1'b0);
    rst       = 1'b0;
    frm_valid = 1'b0;
    mq.delete();
    pend.delete();
    mpos = 0;
    merr = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (pend.size() > 0 || mq.size() > 0); k++) step(1'b1, 1'b1);
    chk("drain_timeout", pend.size() + mq.size(), 0);
  endtask

  initial begin
    rst = 1'b1; frm_valid = 1'b0; out_ready = 1'b0; frm_data = '0;
    mpos = 0; merr = 1'b0;
    @(negedge clk);
    do_reset();

    // single frame, consumer always ready
    pend.push_back(mk(1, 2, 3, 4, 5));
    drain();
    step(1'b1, 1'b1);

    // same frame, consumer ready toggling
    pend.push_back(mk(1, 2, 3, 4, 5));
    for (int i = 0; i < 12; i++) step(i % 2 == 0, 1'b1);
    drain();

    // back-to-back frames under back-pressure, then release
    pend.push_back(mk(10, 20, 30, 40, 50));
    pend.push_back(mk(60, 61, 62, 63, 64));
    pend.push_back(mk(0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    drain();
    step(1'b1, 1'b1);

    // reset in the middle of A with B buffered
    pend.push_back(mk(10, 20, 30, 40, 50));
    pend.push_back(mk(60, 61, 62, 63, 64));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    do_reset();
    pend.push_back(mk(7, 8, 9, 10, 11));
    drain();

    // out-of-order frame then a legal one
    pend.push_back(mk(5, 1, 2, 3, 4));
    pend.push_back(mk(7, 7, 7, 7, 7));
    drain();
    step(1'b1, 1'b1);

    // random frames, random gaps and back-pressure
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int a[5];
      frame_t fr;
      for (int i = 0; i < N; i++) a[i] = $urandom_range(0, 65535);
      if ($urandom_range(0, 9) < 8) a.sort();
      for (int i = 0; i < N; i++) fr[i] = a[i][DW-1:0];
      pend.push_back(fr);
      for (int c = 0; c < 6; c++) step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
